// File: rtl/whackamole_pkg.sv
// Shared widths, LFSR constants and display helper for the whack-a-mole core.
package whackamole_pkg;
  localparam int POS_W = 3;
  localparam int LED_W = 8;
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;  // x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

  // One-hot LED pattern for a hole index.
  function automatic logic [LED_W-1:0] pos_onehot(input logic [POS_W-1:0] p);
    return LED_W'(1) << p;
  endfunction
endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR. Feedback is the XOR of the tapped bits
// and shifts in at bit 0. Bit 7 is always tapped, so a non-zero seed never
// decays to the all-zero lock-up state.
module lfsr8 import whackamole_pkg::*; #(
  parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] state
);
  logic [7:0] state_q, state_d;

  // Next state: shift left, feed back the parity of the tapped bits.
  always_comb begin
    state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;
endmodule

// File: rtl/whackamole_core.sv
// Whack-a-mole core: mole placement, guess latch/evaluate, hit/miss pulses
// and the 8-LED display (one-hot mole, or a timed all-on/all-off flash).
module whackamole_core import whackamole_pkg::*; #(
  parameter int         MOLE_PERIOD  = 50_000_000,
  parameter int         FLASH_CYCLES = 25_000_000,
  parameter logic [7:0] LFSR_SEED    = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] user_guess,
  input  logic             guess_now,
  input  logic             eval_now,
  output logic [POS_W-1:0] mole_pos,
  output logic             mole_change,
  output logic             guess_correct,
  output logic             guess_wrong,
  output logic [LED_W-1:0] led
);
  localparam int TMR_W = $clog2(MOLE_PERIOD);
  localparam int FL_W  = $clog2(FLASH_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MOLE_PERIOD - 1);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLASH_CYCLES);

  logic [7:0] lfsr_state;
  logic [4:0] lfsr_unused;

  logic             guess_prev_q, guess_prev_d;
  logic             eval_prev_q, eval_prev_d;
  logic [POS_W-1:0] guess_reg_q, guess_reg_d;
  logic             guess_valid_q, guess_valid_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [POS_W-1:0] mole_pos_q, mole_pos_d;
  logic             mole_change_q, mole_change_d;
  logic             correct_q, correct_d;
  logic             wrong_q, wrong_d;
  logic [FL_W-1:0]  flash_q, flash_d;
  logic [LED_W-1:0] led_q, led_d;

  logic             guess_edge, eval_edge, eval_ok, hit, miss, expire, relocate;
  logic [POS_W-1:0] eff_guess, cand;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .state(lfsr_state)
  );

  // Only the low bits pick a hole; the rest just keep the sequence long.
  assign lfsr_unused = lfsr_state[7:3];

  // Strobe edges, hit/miss decision against the current (pre-move) mole,
  // and the relocation candidate that is guaranteed to differ from it.
  always_comb begin
    guess_edge = guess_now & ~guess_prev_q;
    eval_edge  = eval_now & ~eval_prev_q;
    eval_ok    = eval_edge & (guess_valid_q | guess_edge);
    eff_guess  = guess_edge ? user_guess : guess_reg_q;
    hit        = eval_ok & (eff_guess == mole_pos_q);
    miss       = eval_ok & ~hit;
    expire     = (timer_q == TMR_LAST);
    relocate   = hit | expire;
    cand       = lfsr_state[POS_W-1:0];
    if (cand == mole_pos_q) cand = cand + POS_W'(1);
  end

  // Guess latch: an edge loads it, an accepted evaluation consumes it.
  always_comb begin
    guess_prev_d  = guess_now;
    eval_prev_d   = eval_now;
    guess_reg_d   = guess_reg_q;
    guess_valid_d = guess_valid_q;
    if (guess_edge) begin
      guess_reg_d   = user_guess;
      guess_valid_d = 1'b1;
    end
    if (eval_ok) guess_valid_d = 1'b0;
  end

  // Mole timer and relocation; a hit and an expiry together move it once.
  always_comb begin
    timer_d       = relocate ? '0 : timer_q + TMR_W'(1);
    mole_pos_d    = relocate ? cand : mole_pos_q;
    mole_change_d = relocate;
    correct_d     = hit;
    wrong_d       = miss;
  end

  // Display: a result loads the flash pattern and counter; the pattern is
  // held while more than one flash cycle remains, then the one-hot returns.
  always_comb begin
    flash_d = flash_q;
    led_d   = led_q;
    if (hit) begin
      led_d   = '1;
      flash_d = FL_LOAD;
    end else if (miss) begin
      led_d   = '0;
      flash_d = FL_LOAD;
    end else begin
      if (flash_q != '0) flash_d = flash_q - FL_W'(1);
      if (flash_q <= FL_W'(1)) led_d = pos_onehot(mole_pos_d);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guess_prev_q  <= 1'b0;
      eval_prev_q   <= 1'b0;
      guess_reg_q   <= '0;
      guess_valid_q <= 1'b0;
      timer_q       <= '0;
      mole_pos_q    <= '0;
      mole_change_q <= 1'b0;
      correct_q     <= 1'b0;
      wrong_q       <= 1'b0;
      flash_q       <= '0;
      led_q         <= LED_W'(1);
    end else begin
      guess_prev_q  <= guess_prev_d;
      eval_prev_q   <= eval_prev_d;
      guess_reg_q   <= guess_reg_d;
      guess_valid_q <= guess_valid_d;
      timer_q       <= timer_d;
      mole_pos_q    <= mole_pos_d;
      mole_change_q <= mole_change_d;
      correct_q     <= correct_d;
      wrong_q       <= wrong_d;
      flash_q       <= flash_d;
      led_q         <= led_d;
    end
  end

  assign mole_pos      = mole_pos_q;
  assign mole_change   = mole_change_q;
  assign guess_correct = correct_q;
  assign guess_wrong   = wrong_q;
  assign led           = led_q;
endmodule

// File: tb/tb_whackamole_core.sv
// Directed bench for whackamole_core with a cycle model of mole/LED state
// and a scoreboard of expected hit/miss results.
module tb_whackamole_core;
  localparam int MP = 16;
  localparam int FC = 4;

  logic       clk, rst_n;
  logic [2:0] user_guess;
  logic       guess_now, eval_now;
  logic [2:0] mole_pos;
  logic       mole_change, guess_correct, guess_wrong;
  logic [7:0] led;

  whackamole_core #(.MOLE_PERIOD(MP), .FLASH_CYCLES(FC), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .user_guess(user_guess), .guess_now(guess_now),
    .eval_now(eval_now), .mole_pos(mole_pos), .mole_change(mole_change),
    .guess_correct(guess_correct), .guess_wrong(guess_wrong), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, feedback into bit 0.
  logic [7:0] lf;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lf <= 8'hA5;
    else        lf <= {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
  end

  int checks = 0;
  int errors = 0;
  logic [1:0] sb[$];

  logic [2:0] m_pos, m_greg;
  logic [7:0] m_led;
  logic       m_change, m_gvalid, m_gprev, m_eprev;
  int         m_timer, m_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 3'd0; m_greg = 3'd0; m_led = 8'h01; m_change = 1'b0;
    m_gvalid = 1'b0; m_gprev = 1'b0; m_eprev = 1'b0; m_timer = 0; m_fl = 0;
    sb.delete();
  endtask

  // Advance one clock: predict from pre-edge state, then compare after it.
  task automatic tick();
    logic ge, ee, rv, hit, miss, rl;
    logic [2:0] g, c, np;
    logic [1:0] exp_res;
    ge   = guess_now && !m_gprev;
    ee   = eval_now && !m_eprev;
    rv   = ee && (m_gvalid || ge);
    g    = ge ? user_guess : m_greg;
    hit  = rv && (g == m_pos);
    miss = rv && !hit;
    if (rv) sb.push_back({hit, miss});
    rl = hit || (m_timer == MP - 1);
    c  = lf[2:0];
    if (c == m_pos) c = c + 3'd1;
    np = rl ? c : m_pos;
    @(posedge clk); #1;
    m_gprev = guess_now; m_eprev = eval_now;
    if (ge) m_greg = user_guess;
    if (rv) m_gvalid = 1'b0; else if (ge) m_gvalid = 1'b1;
    m_timer  = rl ? 0 : m_timer + 1;
    m_change = rl;
    m_pos    = np;
    if (hit)       begin m_led = 8'hFF; m_fl = FC - 1; end
    else if (miss) begin m_led = 8'h00; m_fl = FC - 1; end
    else if (m_fl > 0) m_fl--;
    else m_led = 8'h01 << np;
    chk("mole_pos", 32'(mole_pos), 32'(m_pos));
    chk("mole_change", 32'(mole_change), 32'(m_change));
    chk("led", 32'(led), 32'(m_led));
    if (rv) begin
      exp_res = sb.pop_front();
      chk("result", 32'({guess_correct, guess_wrong}), 32'(exp_res));
    end else begin
      chk("no_result", 32'({guess_correct, guess_wrong}), 32'd0);
    end
  endtask

  initial begin
    logic [2:0] old;
    int n, cnt;
    rst_n = 1'b0; user_guess = 3'd0; guess_now = 1'b0; eval_now = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_pos", 32'(mole_pos), 32'd0);
    chk("rst_led", 32'(led), 32'h01);
    chk("rst_pulses", 32'({mole_change, guess_correct, guess_wrong}), 32'd0);

    // First auto-relocation lands exactly MP clocks after reset release.
    n = 0;
    for (int i = 1; i <= MP + 4; i++) begin
      tick();
      if (mole_change && n == 0) n = i;
    end
    chk("first_change_clk", 32'(n), 32'(MP));
    // Resynchronise to a fresh relocation so the next steps see a low timer.
    for (int i = 0; i < 2 * MP && !m_change; i++) tick();
    chk("resync", 32'(mole_change), 32'd1);

    // Hit: latch the mole position, evaluate two clocks later.
    old = m_pos; user_guess = old; guess_now = 1'b1; tick();
    guess_now = 1'b0; tick();
    eval_now = 1'b1; tick();
    chk("hit_pulse", 32'(guess_correct), 32'd1);
    chk("hit_change", 32'(mole_change), 32'd1);
    chk("hit_moved", 32'(mole_pos != old), 32'd1);
    cnt = (led == 8'hFF) ? 1 : 0;
    eval_now = 1'b0;
    repeat (5) begin tick(); cnt += (led == 8'hFF) ? 1 : 0; end
    chk("hit_flash_len", 32'(cnt), 32'(FC));

    // Miss: guess one hole past the mole.
    old = m_pos; user_guess = old + 3'd1; guess_now = 1'b1; tick();
    guess_now = 1'b0; eval_now = 1'b1; tick();
    chk("miss_pulse", 32'(guess_wrong), 32'd1);
    chk("miss_pos_kept", 32'(mole_pos), 32'(old));
    chk("miss_led", 32'(led), 32'h00);
    eval_now = 1'b0;
    repeat (5) tick();

    // Evaluate with no latched guess: nothing happens.
    cnt = 0;
    eval_now = 1'b1; tick(); cnt += guess_correct + guess_wrong;
    eval_now = 1'b0; tick(); cnt += guess_correct + guess_wrong;
    chk("eval_no_guess", 32'(cnt), 32'd0);

    // One guess, eval held high for 10 clocks: one result only.
    user_guess = 3'd5; guess_now = 1'b1; tick();
    guess_now = 1'b0; tick();
    cnt = 0; eval_now = 1'b1;
    repeat (10) begin tick(); cnt += guess_correct + guess_wrong; end
    eval_now = 1'b0; tick();
    chk("eval_held_once", 32'(cnt), 32'd1);
    repeat (4) tick();

    // Simultaneous guess and eval: the live guess bypasses the latch.
    user_guess = m_pos; guess_now = 1'b1; eval_now = 1'b1; tick();
    chk("bypass_hit", 32'(guess_correct), 32'd1);
    guess_now = 1'b0; eval_now = 1'b0;
    repeat (5) tick();

    // Eval on the timer-expiry edge: one move, judged on the old mole.
    for (int i = 0; i < 3 * MP && m_timer != MP - 3; i++) tick();
    chk("align_timer", 32'(m_timer), 32'(MP - 3));
    old = m_pos; user_guess = old; guess_now = 1'b1; tick();
    guess_now = 1'b0; tick();
    eval_now = 1'b1; tick();
    chk("expiry_hit", 32'(guess_correct), 32'd1);
    chk("expiry_change", 32'(mole_change), 32'd1);
    eval_now = 1'b0; tick();
    chk("expiry_single", 32'(mole_change), 32'd0);
    repeat (3) tick();

    // Async reset in the middle of a miss flash.
    user_guess = m_pos + 3'd2; guess_now = 1'b1; eval_now = 1'b1; tick();
    guess_now = 1'b0; eval_now = 1'b0; tick();
    chk("pre_rst_flash", 32'(led), 32'h00);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_pos", 32'(mole_pos), 32'd0);
    chk("async_rst_led", 32'(led), 32'h01);
    chk("async_rst_pulses", 32'({mole_change, guess_correct, guess_wrong}), 32'd0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (MP + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
